run_controller: RTL and testbench
=================================

Name: run_controller

Overview:
- Top-level run sequencer for the 9-bit single-cycle core. Implements the start/hold/program/done handshake with the testbench.
- Drives a synchronous clear to the program counter, register file and data memory, and a clock-enable that gates all core state updates.
- Converts the decoder's halt indication into a sticky done flag.
- Counts executed cycles for performance reporting.

Parameters:
CNT_W, 16, width of cycle_count
INIT_CYCLES, 2, cycles core_rst stays asserted in INIT (legal range 1..15)
MAX_CYCLES, 65535, watchdog limit in RUN cycles (used only with the optional feature; must be < 2**CNT_W)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  testbench start level; high = hold, falling edge launches a run
halt_in  input  1  halt decode from control_decoder for the current instruction
core_rst  output  1  synchronous clear to pc/register file/data memory
core_en  output  1  core state-update enable (pc advance, reg/mem writes)
done  output  1  program finished, sticky until next start
timeout  output  1  run ended by watchdog (0 when feature absent)
cycle_count  output  CNT_W  RUN cycles executed in the current/last run
state_dbg  output  3  encoded FSM state: IDLE=0, HOLD=1, INIT=2, RUN=3, DONE=4

Behaviour:
- Reset (async, any state, any time) forces the reset values immediately, without waiting for clk:
  - state=IDLE, core_rst=1, core_en=0, done=0, timeout=0, cycle_count=0, init counter=0.
- Outputs are Moore-decoded from registered state plus the registered count, done and timeout. There is no combinational path from any input to any output.
- IDLE: core_rst=1, core_en=0. start=1 -> HOLD.
- HOLD: core_rst=1, core_en=0, done=0. Stays while start=1. start=0 -> INIT; the init counter loads 0 and cycle_count clears to 0 on that edge.
- INIT: core_rst=1, core_en=0. The init counter increments each cycle. After exactly INIT_CYCLES cycles in INIT -> RUN.
- RUN: core_rst=0, core_en=1. Each RUN-cycle edge increments cycle_count, saturating at all-ones. The exits are checked at each edge in this priority order:
  1. start=1 -> HOLD (abort/restart); cycle_count holds; done stays 0.
  2. halt_in=1 -> DONE; the halting cycle is counted.
  3. Watchdog expiry -> DONE with timeout (optional feature only).
- Latency: halt_in high in RUN cycle k -> done=1 and core_en=0 starting in cycle k+1; cycle_count=k.
- DONE: done=1, core_en=0, core_rst=0, so architectural state stays visible to the testbench. cycle_count and timeout hold. start=1 -> HOLD; done and timeout drop on that same edge.
- halt_in is ignored in every state except RUN.
- start is level-sensitive. A start held high across multiple cycles produces exactly one run, launched after it falls.
- Unused state encodings 5..7 -> IDLE on the next edge.

Optional Feature:
- Macro: RUN_CONTROLLER_WATCHDOG_EN.
- Defined:
  - In RUN, if halt_in=0, start=0 and cycle_count==MAX_CYCLES-1 at the edge -> DONE, timeout=1, cycle_count=MAX_CYCLES.
  - halt_in in that same cycle wins: DONE with timeout=0.
- Undefined: no watchdog logic; timeout is tied to 0; a run ends only by halt_in or start.

Test Plan:
- Reset, start=1 for 3 cycles, then 0 -> core_rst=1 through HOLD and exactly 2 INIT cycles; core_en=1 starts in the next cycle; halt_in pulsed in the 10th RUN cycle -> done=1 and core_en=0 from the next cycle, cycle_count=10, state_dbg=4.
- In DONE, assert start for 1 cycle -> done=0 on the next edge, state_dbg=1; cycle_count stays 10 until INIT entry, then reads 0; a second run halting at RUN cycle 4 -> cycle_count=4.
- halt_in held high throughout IDLE, HOLD and INIT -> no early done; the run enters RUN, and the first RUN cycle with halt_in=1 -> done, cycle_count=1.
- Async reset asserted mid-RUN between clock edges -> core_rst=1, core_en=0, done=0, cycle_count=0, state_dbg=0 immediately; after release, the FSM waits in IDLE for start.
- start=1 and halt_in=1 in the same RUN cycle -> HOLD, done stays 0; start=0 -> fresh INIT and RUN.
- With RUN_CONTROLLER_WATCHDOG_EN, MAX_CYCLES=20, halt_in never asserted -> done=1, timeout=1, cycle_count=20. Without the macro, the same stimulus keeps core_en=1 and timeout=0 indefinitely.

Source files
------------

// File: rtl/run_controller.sv
// ---------------------------------------------------------------------------
// run_controller
//
// Top-level run sequencer for the 9-bit single-cycle core. It handles the
// start/hold/program/done handshake with the testbench and drives the core:
//   - core_rst clears the pc, register file and data memory while the core
//     is not running.
//   - core_en gates every core state update, so the core only advances in RUN.
//   - The decoder's halt is turned into a sticky done flag.
//   - RUN cycles are counted for performance reporting.
//
// Optional feature: define RUN_CONTROLLER_WATCHDOG_EN to end a run after
// MAX_CYCLES RUN cycles with timeout=1. Without the macro, timeout stays 0
// and a run ends only through halt_in or start.
//
// Parameters:
//   CNT_W        width of cycle_count
//   INIT_CYCLES  cycles core_rst stays asserted in INIT (1..15)
//   MAX_CYCLES   watchdog limit in RUN cycles (< 2**CNT_W)
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   start        start level; high holds, falling edge launches a run
//   halt_in      halt decode for the current instruction
//   core_rst     synchronous clear to pc / register file / data memory
//   core_en      core state-update enable
//   done         program finished, sticky until the next start
//   timeout      run ended by the watchdog
//   cycle_count  RUN cycles executed in the current/last run
//   state_dbg    FSM state: IDLE=0, HOLD=1, INIT=2, RUN=3, DONE=4
// ---------------------------------------------------------------------------
module run_controller #(
  parameter int CNT_W       = 16,
  parameter int INIT_CYCLES = 2,
  parameter int MAX_CYCLES  = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_in,
  output logic             core_rst,
  output logic             core_en,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_INIT = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Last value the init counter reaches before RUN is entered.
  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

`ifdef RUN_CONTROLLER_WATCHDOG_EN
  // Count value at which the next RUN edge is the last one allowed.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);
`endif

  // Out-of-range parameters leave an empty marker block in the hierarchy so
  // a bad configuration is easy to spot when browsing the elaborated design.
  if ((INIT_CYCLES < 1) || (INIT_CYCLES > 15) || (MAX_CYCLES < 1)) begin : g_param_out_of_range
  end

  state_t           state_r, state_next_s;
  logic [3:0]       init_cnt_r, init_cnt_next_s;
  logic [CNT_W-1:0] count_r, count_next_s, count_inc_s;
  logic             done_r, done_next_s;
  logic             timeout_r, timeout_next_s;
  logic             core_rst_r, core_rst_next_s;
  logic             core_en_r, core_en_next_s;

  // Saturating increment of the RUN cycle counter.
  always_comb begin
    count_inc_s = count_r;
    if (count_r == CNT_MAX) begin
      count_inc_s = count_r;
    end else begin
      count_inc_s = count_r + CNT_ONE;
    end
  end

  // Next-state, counter and flag logic.
  always_comb begin
    state_next_s    = state_r;
    init_cnt_next_s = init_cnt_r;
    count_next_s    = count_r;
    done_next_s     = done_r;
    timeout_next_s  = timeout_r;
    case (state_r)
      ST_IDLE: begin
        done_next_s    = 1'b0;
        timeout_next_s = 1'b0;
        if (start) begin
          state_next_s = ST_HOLD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        done_next_s    = 1'b0;
        timeout_next_s = 1'b0;
        if (!start) begin
          state_next_s    = ST_INIT;
          init_cnt_next_s = 4'd0;
          count_next_s    = {CNT_W{1'b0}};
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      ST_INIT: begin
        done_next_s     = 1'b0;
        timeout_next_s  = 1'b0;
        init_cnt_next_s = init_cnt_r + 4'd1;
        if (init_cnt_r == INIT_LAST) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_RUN: begin
        // Abort has priority over halt; an aborted cycle is not counted.
        if (start) begin
          state_next_s = ST_HOLD;
        end else if (halt_in) begin
          state_next_s = ST_DONE;
          count_next_s = count_inc_s;
          done_next_s  = 1'b1;
`ifdef RUN_CONTROLLER_WATCHDOG_EN
        end else if (count_r == WD_LAST) begin
          state_next_s   = ST_DONE;
          count_next_s   = count_inc_s;
          done_next_s    = 1'b1;
          timeout_next_s = 1'b1;
`endif
        end else begin
          state_next_s = ST_RUN;
          count_next_s = count_inc_s;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_next_s   = ST_HOLD;
          done_next_s    = 1'b0;
          timeout_next_s = 1'b0;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s    = ST_IDLE;
        init_cnt_next_s = 4'd0;
        done_next_s     = 1'b0;
        timeout_next_s  = 1'b0;
      end
    endcase
  end

  // Core control decoded from the next state, so the registered outputs
  // line up with the state register.
  always_comb begin
    core_rst_next_s = 1'b1;
    core_en_next_s  = 1'b0;
    case (state_next_s)
      ST_RUN: begin
        core_rst_next_s = 1'b0;
        core_en_next_s  = 1'b1;
      end
      ST_DONE: begin
        core_rst_next_s = 1'b0;
        core_en_next_s  = 1'b0;
      end
      default: begin
        core_rst_next_s = 1'b1;
        core_en_next_s  = 1'b0;
      end
    endcase
  end

  // State, counters, flags and registered core controls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      init_cnt_r <= 4'd0;
      count_r    <= {CNT_W{1'b0}};
      done_r     <= 1'b0;
      timeout_r  <= 1'b0;
      core_rst_r <= 1'b1;
      core_en_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      init_cnt_r <= init_cnt_next_s;
      count_r    <= count_next_s;
      done_r     <= done_next_s;
      timeout_r  <= timeout_next_s;
      core_rst_r <= core_rst_next_s;
      core_en_r  <= core_en_next_s;
    end
  end

  assign core_rst    = core_rst_r;
  assign core_en     = core_en_r;
  assign done        = done_r;
  assign timeout     = timeout_r;
  assign cycle_count = count_r;
  assign state_dbg   = state_r;

endmodule

// File: tb/tb_run_controller.sv
// ---------------------------------------------------------------------------
// tb_run_controller
//
// Directed self-checking bench for run_controller (CNT_W=16, INIT_CYCLES=2,
// MAX_CYCLES=20). Inputs change 1 time unit after a rising edge and outputs
// are sampled at that same point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_run_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic        halt_in;
  logic        core_rst;
  logic        core_en;
  logic        done;
  logic        timeout;
  logic [15:0] cycle_count;
  logic [2:0]  state_dbg;

  int n_assert;
  int n_fail;

  run_controller #(
    .CNT_W       (16),
    .INIT_CYCLES (2),
    .MAX_CYCLES  (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .halt_in     (halt_in),
    .core_rst    (core_rst),
    .core_en     (core_en),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycle_count),
    .state_dbg   (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full output snapshot: state, core_rst, core_en, done, timeout, count.
  task automatic chk_all(input string tag, input logic [2:0] st, input logic rs,
                         input logic en, input logic dn, input logic to,
                         input logic [15:0] cnt);
    chk({tag, ".state"},    32'(state_dbg),   32'(st));
    chk({tag, ".core_rst"}, 32'(core_rst),    32'(rs));
    chk({tag, ".core_en"},  32'(core_en),     32'(en));
    chk({tag, ".done"},     32'(done),        32'(dn));
    chk({tag, ".timeout"},  32'(timeout),     32'(to));
    chk({tag, ".count"},    32'(cycle_count), 32'(cnt));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b0;
    start    = 1'b0;
    halt_in  = 1'b0;

    // Reset values appear without a clock edge.
    #2 reset = 1'b1;
    #1;
    chk_all("reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    tick();
    reset = 1'b0;
    tick();
    chk_all("idle", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);

    // Run 1: start high 3 cycles, 2 INIT cycles, halt in RUN cycle 10.
    start = 1'b1;
    tick();
    chk_all("hold1", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    tick();
    tick();
    chk("hold3.state", 32'(state_dbg), 32'd1);
    start = 1'b0;
    tick();
    chk_all("init1", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    tick();
    chk_all("init2", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    tick();
    chk_all("run1", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 9; i++) tick();
    chk_all("run10", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 16'd9);
    halt_in = 1'b1;
    tick();
    halt_in = 1'b0;
    chk_all("done1", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 16'd10);
    tick();
    chk_all("done1_sticky", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 16'd10);

    // Run 2: restart from DONE, halt in RUN cycle 4.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("restart_hold", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd10);
    tick();
    chk_all("restart_init", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    tick();
    tick();
    chk("run2_entry.state", 32'(state_dbg), 32'd3);
    tick();
    tick();
    tick();
    halt_in = 1'b1;
    tick();
    halt_in = 1'b0;
    chk_all("done2", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4);

    // Run 3: halt_in held through HOLD/INIT is ignored until RUN.
    halt_in = 1'b1;
    start   = 1'b1;
    tick();
    chk_all("halt_hold", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4);
    start = 1'b0;
    tick();
    chk_all("halt_init1", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    tick();
    chk_all("halt_init2", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    tick();
    chk_all("halt_run1", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    tick();
    halt_in = 1'b0;
    chk_all("done3", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);

    // Run 4: start and halt together in RUN -> abort to HOLD, no done.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("run4_entry.state", 32'(state_dbg), 32'd3);
    tick();
    tick();
    start   = 1'b1;
    halt_in = 1'b1;
    tick();
    chk_all("abort", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    start   = 1'b0;
    halt_in = 1'b0;
    tick();
    chk_all("abort_init", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    tick();
    tick();
    chk_all("abort_rerun", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    tick();
    tick();
    chk("prereset.count", 32'(cycle_count), 32'd2);

    // Async reset between edges mid-RUN.
    #3 reset = 1'b1;
    #1;
    chk_all("async_reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk_all("post_reset_idle", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);

    // Run 5: no halt, watchdog at 20 RUN cycles when enabled.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("wd_entry.state", 32'(state_dbg), 32'd3);
    for (int i = 0; i < 19; i++) tick();
    chk_all("wd_run20", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 16'd19);
    tick();
`ifdef RUN_CONTROLLER_WATCHDOG_EN
    chk_all("wd_expire", 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 16'd20);
    tick();
    chk_all("wd_sticky", 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 16'd20);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("wd_clear", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd20);
`else
    chk_all("nowd_past20", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 16'd20);
    for (int i = 0; i < 10; i++) tick();
    chk_all("nowd_past30", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 16'd30);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
